// File: rtl/reaction_time_bcd_reader_if.sv
// Start/busy/done handshake and data bus between game controller and BCD reader.
interface reaction_time_bcd_reader_if #(
  parameter int unsigned WIDTH  = 13,
  parameter int unsigned DIGITS = 4
);
  logic                    Start;
  logic [WIDTH-1:0]        In;
  logic                    Busy;
  logic                    Done;
  logic [4*DIGITS-1:0]     Digits;

  // Controller side: requests conversions and consumes the digits.
  modport master (
    output Start,
    output In,
    input  Busy,
    input  Done,
    input  Digits
  );

  // Reader side: accepts requests and publishes the BCD result.
  modport slave (
    input  Start,
    input  In,
    output Busy,
    output Done,
    output Digits
  );
endinterface

// File: rtl/reaction_time_bcd_reader.sv
// Sequential double-dabble converter: reads the stored binary reaction time
// and produces packed BCD digits, one shift per clock.
module reaction_time_bcd_reader #(
  parameter int unsigned WIDTH  = 13,
  parameter int unsigned DIGITS = 4
) (
  input  logic                        Clock,
  input  logic                        CLR,
  reaction_time_bcd_reader_if.slave   bus
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   bin;
  logic [BCD_W-1:0]   bcd;
  logic [CNT_W-1:0]   count;
  logic               busy_q;
  logic               done_q;
  logic [BCD_W-1:0]   digits_q;

  logic [BCD_W-1:0]   bcd_adj;
  logic [BCD_W-1:0]   bcd_next;

  // Add-3 correction on every digit in parallel, then shift in the next binary bit.
  always_comb begin
    bcd_adj = bcd;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
    end
    bcd_next = {bcd_adj[BCD_W-2:0], bin[WIDTH-1]};
  end

  // Control FSM with datapath and registered Busy/Done/Digits.
  always_ff @(posedge Clock) begin
    if (CLR) begin
      state    <= IDLE;
      bin      <= '0;
      bcd      <= '0;
      count    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      digits_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.Start) begin
            bin    <= bus.In;
            bcd    <= '0;
            count  <= '0;
            busy_q <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          bcd   <= bcd_next;
          bin   <= {bin[WIDTH-2:0], 1'b0};
          count <= count + CNT_W'(1);
          // Last shift: publish the result directly, skipping the bcd register.
          if (count == CNT_W'(WIDTH - 1)) begin
            digits_q <= bcd_next;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.Busy   = busy_q;
  assign bus.Done   = done_q;
  assign bus.Digits = digits_q;

endmodule

// File: tb/tb_reaction_time_bcd_reader.sv
// Self-checking bench for reaction_time_bcd_reader: vector table, scoreboard
// of expected digits, latency/handshake checks and a stepped sweep.
module tb_reaction_time_bcd_reader;

  localparam int unsigned WIDTH  = 13;
  localparam int unsigned DIGITS = 4;

  typedef struct {
    logic [12:0] in_val;
    logic [15:0] exp_digits;
  } vec_t;

  logic Clock;
  logic CLR;

  reaction_time_bcd_reader_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

  reaction_time_bcd_reader #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .Clock (Clock),
    .CLR   (CLR),
    .bus   (bus)
  );

  int          vectors;
  int          miscompares;
  int          done_cnt;
  int          cyc;
  bit          mon_en;
  logic [15:0] hold_digits;
  logic [15:0] sb_q[$];

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  always @(posedge Clock) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Independent reference: decimal digits by division.
  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    r[3:0]   = 4'(v % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[11:8]  = 4'((v / 100) % 10);
    r[15:12] = 4'((v / 1000) % 10);
    return r;
  endfunction

  // Scoreboard: pop on every Done; otherwise Digits must hold the last result.
  always @(negedge Clock) begin
    if (mon_en && !CLR) begin
      if (bus.Done) begin
        done_cnt++;
        if (sb_q.size() == 0) begin
          chk("unexpected_done", 32'(bus.Digits), 32'hFFFF_FFFF);
        end else begin
          logic [15:0] e;
          bit ok;
          e = sb_q.pop_front();
          chk("digits", 32'(bus.Digits), 32'(e));
          ok = 1'b1;
          for (int d = 0; d < 4; d++) if (bus.Digits[4*d +: 4] > 4'd9) ok = 1'b0;
          chk("digit_range", 32'(ok), 32'd1);
          hold_digits = e;
        end
      end else begin
        chk("digits_hold", 32'(bus.Digits), 32'(hold_digits));
      end
    end
  end

  // Wait up to a bounded number of negedges for Done; advances at least once.
  task automatic wait_done(output int at_cyc, output bit got);
    got = 1'b0;
    at_cyc = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge Clock);
      if (bus.Done) begin
        got = 1'b1;
        at_cyc = cyc;
      end
    end
  endtask

  // One full conversion with latency and pulse-width checks.
  task automatic convert(input logic [12:0] v, input logic [15:0] e);
    int busy_n;
    bit got;
    @(negedge Clock);
    bus.Start = 1'b1;
    bus.In    = v;
    sb_q.push_back(e);
    @(negedge Clock);
    bus.Start = 1'b0;
    bus.In    = 13'($urandom);
    busy_n = 0;
    got    = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      if (bus.Done) got = 1'b1;
      else begin
        if (bus.Busy) busy_n++;
        @(negedge Clock);
      end
    end
    chk("done_seen", 32'(got), 32'd1);
    chk("busy_cycles", 32'(busy_n), 32'(WIDTH));
    chk("busy_at_done", 32'(bus.Busy), 32'd0);
    @(negedge Clock);
    chk("done_pulse_width", 32'(bus.Done), 32'd0);
  endtask

  initial begin
    vec_t tbl[$];
    int   c1, c2, d0;
    bit   got;

    vectors = 0; miscompares = 0; done_cnt = 0; cyc = 0;
    mon_en = 1'b0; hold_digits = '0;
    CLR = 1'b1; bus.Start = 1'b0; bus.In = '0;

    tbl.push_back('{13'd0,    16'h0000});
    tbl.push_back('{13'd8191, 16'h8191});
    tbl.push_back('{13'd1234, 16'h1234});
    tbl.push_back('{13'd1,    16'h0001});
    tbl.push_back('{13'd9,    16'h0009});
    tbl.push_back('{13'd10,   16'h0010});
    tbl.push_back('{13'd99,   16'h0099});
    tbl.push_back('{13'd100,  16'h0100});
    tbl.push_back('{13'd5,    16'h0005});
    tbl.push_back('{13'd999,  16'h0999});
    tbl.push_back('{13'd4000, 16'h4000});
    tbl.push_back('{13'd8000, 16'h8000});
    tbl.push_back('{13'd7,    16'h0007});

    repeat (2) @(negedge Clock);
    CLR = 1'b0;
    mon_en = 1'b1;
    chk("reset_busy",   32'(bus.Busy),   32'd0);
    chk("reset_done",   32'(bus.Done),   32'd0);
    chk("reset_digits", 32'(bus.Digits), 32'd0);

    // Table-driven vectors.
    foreach (tbl[i]) convert(tbl[i].in_val, tbl[i].exp_digits);

    // Start while busy is ignored and In may change after capture.
    @(negedge Clock);
    d0 = done_cnt;
    bus.Start = 1'b1; bus.In = 13'd1234;
    sb_q.push_back(16'h1234);
    @(negedge Clock);
    bus.Start = 1'b0;
    repeat (3) @(negedge Clock);
    bus.In = 13'd42; bus.Start = 1'b1;
    @(negedge Clock);
    bus.Start = 1'b0;
    wait_done(c1, got);
    chk("ign_done_seen", 32'(got), 32'd1);
    repeat (20) @(negedge Clock);
    chk("ign_single_done", 32'(done_cnt - d0), 32'd1);

    // Start held high: back-to-back conversions, WIDTH+2 apart.
    @(negedge Clock);
    bus.Start = 1'b1; bus.In = 13'd999;
    sb_q.push_back(16'h0999);
    wait_done(c1, got);
    chk("hold_first_done", 32'(got), 32'd1);
    bus.In = 13'd5;
    sb_q.push_back(16'h0005);
    wait_done(c2, got);
    chk("hold_second_done", 32'(got), 32'd1);
    bus.Start = 1'b0;
    chk("hold_period", 32'(c2 - c1), 32'(WIDTH + 2));
    repeat (3) @(negedge Clock);

    // Reset in the middle of a conversion aborts it.
    @(negedge Clock);
    bus.Start = 1'b1; bus.In = 13'd4000;
    sb_q.push_back(16'h4000);
    @(negedge Clock);
    bus.Start = 1'b0;
    repeat (5) @(negedge Clock);
    chk("abort_busy_before", 32'(bus.Busy), 32'd1);
    CLR = 1'b1;
    hold_digits = '0;
    sb_q.delete();
    @(negedge Clock);
    CLR = 1'b0;
    chk("abort_busy",   32'(bus.Busy),   32'd0);
    chk("abort_done",   32'(bus.Done),   32'd0);
    chk("abort_digits", 32'(bus.Digits), 32'd0);
    d0 = done_cnt;
    repeat (20) @(negedge Clock);
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
    convert(13'd4000, 16'h4000);

    // Stepped sweep against the decimal reference, plus the top end.
    for (int v = 0; v < 8192; v += 17) convert(13'(v), to_bcd(v));
    for (int v = 8184; v < 8192; v++) convert(13'(v), to_bcd(v));

    repeat (3) @(negedge Clock);
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
